// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared constants for the keycode-to-command front end: HID keycodes that map
// to game commands, the command encoding seen on cmd_code, pending-set bit
// positions, repeat FSM state type and small decode/priority helpers.
// -----------------------------------------------------------------------------
package tetris_pkg;

   // HID usage IDs (letter keys plus arrow-key aliases)
   localparam logic [7:0] KEY_LEFT_A  = 8'h04;  // 'A'
   localparam logic [7:0] KEY_LEFT_B  = 8'h50;  // left arrow
   localparam logic [7:0] KEY_RIGHT_A = 8'h07;  // 'D'
   localparam logic [7:0] KEY_RIGHT_B = 8'h4F;  // right arrow
   localparam logic [7:0] KEY_DOWN_A  = 8'h16;  // 'S'
   localparam logic [7:0] KEY_DOWN_B  = 8'h51;  // down arrow
   localparam logic [7:0] KEY_ROT_A   = 8'h1A;  // 'W'
   localparam logic [7:0] KEY_ROT_B   = 8'h52;  // up arrow
   localparam logic [7:0] KEY_HARD    = 8'h2C;  // space
   localparam logic [7:0] KEY_PAUSE   = 8'h13;  // 'P'

   // Keyboard reports this in every slot when too many keys are down
   localparam logic [31:0] KEYCODE_ROLLOVER = 32'h0101_0101;

   // Command encoding on cmd_code
   localparam logic [2:0] CMD_NONE      = 3'd0;
   localparam logic [2:0] CMD_LEFT      = 3'd1;
   localparam logic [2:0] CMD_RIGHT     = 3'd2;
   localparam logic [2:0] CMD_DOWN      = 3'd3;
   localparam logic [2:0] CMD_ROTATE    = 3'd4;
   localparam logic [2:0] CMD_HARD_DROP = 3'd5;
   localparam logic [2:0] CMD_PAUSE     = 3'd6;

   // Pending-set / key-flag bit index is (command code - 1)
   localparam int unsigned B_LEFT   = 0;
   localparam int unsigned B_RIGHT  = 1;
   localparam int unsigned B_DOWN   = 2;
   localparam int unsigned B_ROTATE = 3;
   localparam int unsigned B_HARD   = 4;
   localparam int unsigned B_PAUSE  = 5;
   localparam int unsigned NUM_CMDS = 6;

   typedef enum logic [1:0] {
      StIdle,
      StDas,
      StRepeat
   } rep_state_e;

   // True if any of the four keycode bytes equals k
   function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] k);
      return (kc[7:0] == k) || (kc[15:8] == k) || (kc[23:16] == k) || (kc[31:24] == k);
   endfunction

   // Highest-priority set bit: PAUSE > HARD_DROP > ROTATE > LEFT > RIGHT > DOWN
   function automatic logic [2:0] prio_code(input logic [NUM_CMDS-1:0] pend);
      logic [2:0] code;
      code = CMD_NONE;
      if      (pend[B_PAUSE])  code = CMD_PAUSE;
      else if (pend[B_HARD])   code = CMD_HARD_DROP;
      else if (pend[B_ROTATE]) code = CMD_ROTATE;
      else if (pend[B_LEFT])   code = CMD_LEFT;
      else if (pend[B_RIGHT])  code = CMD_RIGHT;
      else if (pend[B_DOWN])   code = CMD_DOWN;
      return code;
   endfunction

   // One-hot pending-set mask for a command code (zero for CMD_NONE)
   function automatic logic [NUM_CMDS-1:0] code_mask(input logic [2:0] code);
      logic [NUM_CMDS-1:0] m;
      m = '0;
      unique case (code)
         CMD_LEFT:      m[B_LEFT]   = 1'b1;
         CMD_RIGHT:     m[B_RIGHT]  = 1'b1;
         CMD_DOWN:      m[B_DOWN]   = 1'b1;
         CMD_ROTATE:    m[B_ROTATE] = 1'b1;
         CMD_HARD_DROP: m[B_HARD]   = 1'b1;
         CMD_PAUSE:     m[B_PAUSE]  = 1'b1;
         default:       m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// -----------------------------------------------------------------------------
// key_repeat
// Per-key DAS/ARR auto-repeat. Fires one event on the press, a second after
// DAS_MS ms of continuous hold, then one every ARR_MS ms until release.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_key_down  debounced/qualified key-down flag
//   i_ms_tick   1-cycle pulse every millisecond
//   o_event     1-cycle command event (combinational from state and inputs)
// -----------------------------------------------------------------------------
module key_repeat
   import tetris_pkg::*;
#(
   parameter int unsigned DAS_MS = 170,
   parameter int unsigned ARR_MS = 50,
   parameter int unsigned CNT_W  = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_down,
   input  logic i_ms_tick,
   output logic o_event
);

   rep_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_das_done;
   logic w_arr_done;

   assign w_das_done = i_ms_tick && (r_cnt == CNT_W'(DAS_MS - 1));
   assign w_arr_done = i_ms_tick && (r_cnt == CNT_W'(ARR_MS - 1));

   // Event is Mealy so the press reaches the pending set one edge after the
   // keycode is sampled. A low key suppresses any same-cycle expiry.
   always_comb begin
      o_event = 1'b0;
      if (i_key_down) begin
         unique case (r_state)
            StIdle:   o_event = 1'b1;
            StDas:    o_event = w_das_done;
            StRepeat: o_event = w_arr_done;
            default:  o_event = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else if (!i_key_down) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_state <= StDas;
               r_cnt   <= '0;
            end
            StDas: begin
               if (w_das_done) begin
                  r_state <= StRepeat;
                  r_cnt   <= '0;
               end else if (i_ms_tick) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            StRepeat: begin
               if (w_arr_done) begin
                  r_cnt <= '0;
               end else if (i_ms_tick) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= StIdle;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tetris_key_cmd.sv
// -----------------------------------------------------------------------------
// tetris_key_cmd
// Turns the 4-byte HID keycode word into discrete Tetris commands with DAS/ARR
// auto-repeat for LEFT/RIGHT/DOWN and single-shot ROTATE/HARD_DROP/PAUSE.
// Commands are queued in a 6-bit pending set and presented one at a time,
// highest priority first, on a valid/ready handshake.
// Ports:
//   clk_100MHz   system clock
//   reset_rtl_0  synchronous active-high reset
//   keycode_0    four HID keycode bytes, 0x00 = empty slot
//   cmd_valid    command presented (registered)
//   cmd_ready    game logic accepts the presented command
//   cmd_code     command code, 0 when cmd_valid is low (registered)
//   ms_tick      1-cycle pulse every millisecond (registered)
// -----------------------------------------------------------------------------
module tetris_key_cmd
   import tetris_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned DAS_MS = 170,
   parameter int unsigned ARR_MS = 50
) (
   input  logic        clk_100MHz,
   input  logic        reset_rtl_0,
   input  logic [31:0] keycode_0,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_code,
   output logic        ms_tick
);

   localparam int unsigned PRESC_N = CLK_HZ / 1000;
   localparam int unsigned PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
   localparam int unsigned MAX_MS  = (DAS_MS > ARR_MS) ? DAS_MS : ARR_MS;
   localparam int unsigned CNT_W   = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

   // ---------------------------------------------------------------- prescaler
   logic [PRESC_W-1:0] r_presc;
   logic               r_ms_tick;

   always_ff @(posedge clk_100MHz) begin
      if (reset_rtl_0) begin
         r_presc   <= '0;
         r_ms_tick <= 1'b0;
      end else if (r_presc == PRESC_W'(PRESC_N - 1)) begin
         r_presc   <= '0;
         r_ms_tick <= 1'b1;
      end else begin
         r_presc   <= r_presc + PRESC_W'(1);
         r_ms_tick <= 1'b0;
      end
   end

   // -------------------------------------------------------------- input stage
   logic [31:0]         r_keycode;
   logic [NUM_CMDS-1:0] r_key_state;   // key-down flags seen last cycle
   logic [NUM_CMDS-1:0] w_raw;
   logic [NUM_CMDS-1:0] w_flags;
   logic                w_rollover;

   always_comb begin
      w_raw           = '0;
      w_raw[B_LEFT]   = key_hit(r_keycode, KEY_LEFT_A)  || key_hit(r_keycode, KEY_LEFT_B);
      w_raw[B_RIGHT]  = key_hit(r_keycode, KEY_RIGHT_A) || key_hit(r_keycode, KEY_RIGHT_B);
      w_raw[B_DOWN]   = key_hit(r_keycode, KEY_DOWN_A)  || key_hit(r_keycode, KEY_DOWN_B);
      w_raw[B_ROTATE] = key_hit(r_keycode, KEY_ROT_A)   || key_hit(r_keycode, KEY_ROT_B);
      w_raw[B_HARD]   = key_hit(r_keycode, KEY_HARD);
      w_raw[B_PAUSE]  = key_hit(r_keycode, KEY_PAUSE);
   end

   // A rollover report carries no key information: freeze the flags so no
   // spurious release/press edges are seen.
   assign w_rollover = (r_keycode == KEYCODE_ROLLOVER);
   assign w_flags    = w_rollover ? r_key_state : w_raw;

   always_ff @(posedge clk_100MHz) begin
      if (reset_rtl_0) begin
         r_keycode   <= '0;
         r_key_state <= '0;
      end else begin
         r_keycode   <= keycode_0;
         r_key_state <= w_flags;
      end
   end

   // ------------------------------------------------------------ event sources
   // Opposing horizontal keys cancel: both look released to the repeat FSMs.
   logic       w_left_down;
   logic       w_right_down;
   logic       w_left_ev;
   logic       w_right_ev;
   logic       w_down_ev;
   logic [2:0] w_once_rise;

   assign w_left_down  = w_flags[B_LEFT] && !w_flags[B_RIGHT];
   assign w_right_down = w_flags[B_RIGHT] && !w_flags[B_LEFT];
   assign w_once_rise  = w_flags[B_PAUSE:B_ROTATE] & ~r_key_state[B_PAUSE:B_ROTATE];

   key_repeat #(
      .DAS_MS (DAS_MS),
      .ARR_MS (ARR_MS),
      .CNT_W  (CNT_W)
   ) u_rep_left (
      .i_clk      (clk_100MHz),
      .i_rst      (reset_rtl_0),
      .i_key_down (w_left_down),
      .i_ms_tick  (r_ms_tick),
      .o_event    (w_left_ev)
   );

   key_repeat #(
      .DAS_MS (DAS_MS),
      .ARR_MS (ARR_MS),
      .CNT_W  (CNT_W)
   ) u_rep_right (
      .i_clk      (clk_100MHz),
      .i_rst      (reset_rtl_0),
      .i_key_down (w_right_down),
      .i_ms_tick  (r_ms_tick),
      .o_event    (w_right_ev)
   );

   key_repeat #(
      .DAS_MS (DAS_MS),
      .ARR_MS (ARR_MS),
      .CNT_W  (CNT_W)
   ) u_rep_down (
      .i_clk      (clk_100MHz),
      .i_rst      (reset_rtl_0),
      .i_key_down (w_flags[B_DOWN]),
      .i_ms_tick  (r_ms_tick),
      .o_event    (w_down_ev)
   );

   // ------------------------------------------------------ pending set / output
   logic [NUM_CMDS-1:0] r_pending;
   logic [NUM_CMDS-1:0] w_events;
   logic [NUM_CMDS-1:0] w_accept_mask;
   logic [NUM_CMDS-1:0] w_pend_clr;
   logic                r_cmd_valid;
   logic [2:0]          r_cmd_code;

   assign w_events      = {w_once_rise, w_down_ev, w_right_ev, w_left_ev};
   assign w_accept_mask = (r_cmd_valid && cmd_ready) ? code_mask(r_cmd_code) : '0;
   // Pending set minus the command leaving this cycle; new events are OR'd in
   // afterwards so a same-cycle re-event keeps the bit set.
   assign w_pend_clr    = r_pending & ~w_accept_mask;

   // Output is derived from w_pend_clr (not r_pending) so an accepted command
   // is never presented twice; fresh events appear one cycle after entering.
   always_ff @(posedge clk_100MHz) begin
      if (reset_rtl_0) begin
         r_pending   <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_code  <= CMD_NONE;
      end else begin
         r_pending   <= w_pend_clr | w_events;
         r_cmd_valid <= |w_pend_clr;
         r_cmd_code  <= prio_code(w_pend_clr);
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_code  = r_cmd_code;
   assign ms_tick   = r_ms_tick;

endmodule

// File: tb/tb_tetris_key_cmd.sv
// -----------------------------------------------------------------------------
// tb_tetris_key_cmd
// Directed bench for tetris_key_cmd with CLK_HZ=10_000 (1 ms = 10 cycles).
// Accepted commands are logged with their cycle number for timing checks.
// -----------------------------------------------------------------------------
module tb_tetris_key_cmd;

   logic        clk;
   logic        rst;
   logic [31:0] keycode;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_code;
   logic        ms_tick;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Accepted-command log, written only by the monitor
   logic [2:0] log_code [64];
   int         log_cyc  [64];
   int         n_log = 0;

   tetris_key_cmd #(
      .CLK_HZ (10_000),
      .DAS_MS (170),
      .ARR_MS (50)
   ) dut (
      .clk_100MHz  (clk),
      .reset_rtl_0 (rst),
      .keycode_0   (keycode),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_code    (cmd_code),
      .ms_tick     (ms_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmd_valid && cmd_ready) begin
         if (n_log < 64) begin
            log_code[n_log] = cmd_code;
            log_cyc[n_log]  = cyc;
         end
         n_log = n_log + 1;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int base;
      int ticks;
      int doubles;
      logic prev_tick;
      int d;

      rst       = 1'b1;
      keycode   = 32'h0;
      cmd_ready = 1'b1;
      step(3);
      chk("rst_valid", {31'b0, cmd_valid}, 32'd0);
      chk("rst_code", {29'b0, cmd_code}, 32'd0);
      chk("rst_tick", {31'b0, ms_tick}, 32'd0);
      rst = 1'b0;

      // ms_tick: 10 single-cycle pulses in 100 cycles
      ticks = 0;
      doubles = 0;
      prev_tick = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (ms_tick) ticks++;
         if (ms_tick && prev_tick) doubles++;
         prev_tick = ms_tick;
      end
      chk("tick_count", ticks, 32'd10);
      chk("tick_width", doubles, 32'd0);

      // 1: LEFT press latency and single presentation
      keycode = 32'h0000_0004;
      step(1);
      chk("t1_n0_valid", {31'b0, cmd_valid}, 32'd0);
      step(1);
      chk("t1_n1_valid", {31'b0, cmd_valid}, 32'd0);
      step(1);
      chk("t1_n2_valid", {31'b0, cmd_valid}, 32'd1);
      chk("t1_n2_code", {29'b0, cmd_code}, 32'd1);
      step(1);
      chk("t1_n3_valid", {31'b0, cmd_valid}, 32'd0);
      chk("t1_n3_code", {29'b0, cmd_code}, 32'd0);
      keycode = 32'h0;
      step(20);

      // 2: RIGHT held 275 ms -> events at 0, ~170, +50, +50 ms
      base = n_log;
      keycode = 32'h0000_0007;
      step(2750);
      keycode = 32'h0;
      step(1000);
      chk("t2_count", n_log - base, 32'd4);
      if (n_log - base == 4) begin
         for (int i = 0; i < 4; i++) chk("t2_code", {29'b0, log_code[base + i]}, 32'd2);
         d = log_cyc[base + 1] - log_cyc[base];
         chk("t2_das_gap", {31'b0, (d >= 1691 && d <= 1700)}, 32'd1);
         chk("t2_arr_gap1", log_cyc[base + 2] - log_cyc[base + 1], 32'd500);
         chk("t2_arr_gap2", log_cyc[base + 3] - log_cyc[base + 2], 32'd500);
      end

      // 3: PAUSE, ROTATE, HARD_DROP together while stalled, then drained
      cmd_ready = 1'b0;
      keycode = 32'h2C1A_0013;
      step(10);
      chk("t3_stall_valid", {31'b0, cmd_valid}, 32'd1);
      chk("t3_stall_code", {29'b0, cmd_code}, 32'd6);
      base = n_log;
      cmd_ready = 1'b1;
      step(5);
      chk("t3_count", n_log - base, 32'd3);
      if (n_log - base == 3) begin
         chk("t3_code0", {29'b0, log_code[base]}, 32'd6);
         chk("t3_code1", {29'b0, log_code[base + 1]}, 32'd5);
         chk("t3_code2", {29'b0, log_code[base + 2]}, 32'd4);
         chk("t3_consec1", log_cyc[base + 1] - log_cyc[base], 32'd1);
         chk("t3_consec2", log_cyc[base + 2] - log_cyc[base + 1], 32'd1);
      end
      chk("t3_drained", {31'b0, cmd_valid}, 32'd0);
      keycode = 32'h0;
      step(5);

      // 4: LEFT+RIGHT cancel; dropping RIGHT makes LEFT a fresh press
      base = n_log;
      keycode = 32'h0000_0704;
      step(5000);
      chk("t4_none", n_log - base, 32'd0);
      keycode = 32'h0000_0004;
      step(2);
      chk("t4_n1_valid", {31'b0, cmd_valid}, 32'd0);
      step(1);
      chk("t4_n2_valid", {31'b0, cmd_valid}, 32'd1);
      chk("t4_n2_code", {29'b0, cmd_code}, 32'd1);
      keycode = 32'h0;
      step(20);

      // 5: LEFT held past DAS, then rollover for 100 ms keeps repeating
      base = n_log;
      keycode = 32'h0000_0050;
      step(2000);
      keycode = 32'h0101_0101;
      step(1000);
      keycode = 32'h0;
      step(50);
      chk("t5_count", n_log - base, 32'd4);
      if (n_log - base == 4) begin
         for (int i = 0; i < 4; i++) chk("t5_code", {29'b0, log_code[base + i]}, 32'd1);
         chk("t5_arr_gap", log_cyc[base + 3] - log_cyc[base + 2], 32'd500);
      end

      // 6: reset mid-DAS with DOWN pending; DOWN re-fires after release
      cmd_ready = 1'b0;
      keycode = 32'h0000_0051;
      step(10);
      chk("t6_pre_valid", {31'b0, cmd_valid}, 32'd1);
      chk("t6_pre_code", {29'b0, cmd_code}, 32'd3);
      step(490);
      rst = 1'b1;
      step(1);
      chk("t6_rst_valid", {31'b0, cmd_valid}, 32'd0);
      chk("t6_rst_code", {29'b0, cmd_code}, 32'd0);
      chk("t6_rst_tick", {31'b0, ms_tick}, 32'd0);
      rst = 1'b0;
      cmd_ready = 1'b1;
      step(2);
      chk("t6_n1_valid", {31'b0, cmd_valid}, 32'd0);
      step(1);
      chk("t6_n2_valid", {31'b0, cmd_valid}, 32'd1);
      chk("t6_n2_code", {29'b0, cmd_code}, 32'd3);
      keycode = 32'h0;
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
